// File: rtl/counter_pkg.sv
// Shared definitions for the mod-N counter family: digit sizing, parameter
// legality checks and the count-direction encoding.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam int MODULUS_MIN = 2;
  localparam int MODULUS_MAX = 65536;
  localparam int DIGITS_MIN  = 1;

  // Bits needed to hold 0..m-1; kept at 1 for degenerate m so widths stay legal.
  function automatic int digit_width(input int m);
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic bit modulus_legal(input int m);
    return (m >= MODULUS_MIN) && (m <= MODULUS_MAX);
  endfunction

  function automatic bit digits_legal(input int d);
    return d >= DIGITS_MIN;
  endfunction

endpackage

// File: rtl/mod_n_digit.sv
// One counter digit: parallel load with clamp, modulo step in either
// direction, and a terminal flag for the carry chain.
module mod_n_digit
  import counter_pkg::*;
#(
  parameter int MODULUS = 10,
  parameter int W       = digit_width(MODULUS)
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d_in,
  input  logic         step,
  input  logic         up,
  output logic [W-1:0] q,
  output logic         term
);

  localparam logic [W-1:0] MAX   = W'(MODULUS - 1);
  localparam logic [W:0]   MOD_X = (W+1)'(MODULUS);

  logic         in_range;
  logic [W-1:0] nxt;

  assign in_range = ({1'b0, d_in} < MOD_X);

  always_comb begin
    nxt = q;
    if (load) begin
      nxt = in_range ? d_in : MAX;
    end else if (step) begin
      if (up == DIR_UP) nxt = (q == MAX) ? '0 : q + 1'b1;
      else              nxt = (q == '0)  ? MAX : q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) q <= '0;
    else       q <= nxt;
  end

  assign term = (up == DIR_DOWN) ? (q == '0) : (q == MAX);

endmodule

// File: rtl/mod_n_bcd_counter.sv
// Synchronous multi-digit mod-N up/down counter with parallel load,
// terminal count and carry-out for cascading instances through en/co.
module mod_n_bcd_counter
  import counter_pkg::*;
#(
  parameter int MODULUS = 10,
  parameter int DIGITS  = 4
) (
  input  logic                                    clk,
  input  logic                                    clear,
  input  logic                                    en,
  input  logic                                    up,
  input  logic                                    load,
  input  logic [DIGITS*digit_width(MODULUS)-1:0]  load_val,
  output logic [DIGITS*digit_width(MODULUS)-1:0]  q,
  output logic                                    tc,
  output logic                                    co,
  output logic                                    load_err
);

  localparam int         W     = digit_width(MODULUS);
  localparam logic [W:0] MOD_X = (W+1)'(MODULUS);

  if (!modulus_legal(MODULUS) || !digits_legal(DIGITS)) begin : g_bad_param
    $error("mod_n_bcd_counter: illegal MODULUS=%0d / DIGITS=%0d", MODULUS, DIGITS);
  end

  logic [DIGITS-1:0] term;
  logic [DIGITS-1:0] dig_bad;
  // chain[i] = all digits below i are terminal, from pre-edge values
  logic [DIGITS:0]   chain;

  assign chain[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign chain[i+1] = chain[i] & term[i];
    assign dig_bad[i] = ({1'b0, load_val[i*W +: W]} >= MOD_X);

    mod_n_digit #(
      .MODULUS (MODULUS),
      .W       (W)
    ) u_digit (
      .clk   (clk),
      .clear (clear),
      .load  (load),
      .d_in  (load_val[i*W +: W]),
      .step  (en & chain[i]),
      .up    (up),
      .q     (q[i*W +: W]),
      .term  (term[i])
    );
  end

  assign tc = chain[DIGITS];
  assign co = en & tc & ~load & ~clear;

  always_ff @(posedge clk) begin
    if (clear)     load_err <= 1'b0;
    else if (load) load_err <= |dig_bad;
    else           load_err <= 1'b0;
  end

endmodule

// File: tb/tb_mod_n_bcd_counter.sv
// Directed bench: a 2-digit decade counter driven from a vector table plus
// multi-cycle sequences, and a 3-digit mod-6 counter for wrap/random enable.
module tb_mod_n_bcd_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_clear = 1'b0, a_en = 1'b0, a_up = 1'b1, a_load = 1'b0;
  logic [7:0] a_lv = '0, a_q;
  logic       a_tc, a_co, a_err;

  logic       b_clear = 1'b0, b_en = 1'b0, b_up = 1'b1, b_load = 1'b0;
  logic [8:0] b_lv = '0, b_q;
  logic       b_tc, b_co, b_err;

  mod_n_bcd_counter #(.MODULUS(10), .DIGITS(2)) u_dut_a (
    .clk(clk), .clear(a_clear), .en(a_en), .up(a_up), .load(a_load),
    .load_val(a_lv), .q(a_q), .tc(a_tc), .co(a_co), .load_err(a_err)
  );

  mod_n_bcd_counter #(.MODULUS(6), .DIGITS(3)) u_dut_b (
    .clk(clk), .clear(b_clear), .en(b_en), .up(b_up), .load(b_load),
    .load_val(b_lv), .q(b_q), .tc(b_tc), .co(b_co), .load_err(b_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int dec_b(input logic [8:0] v);
    return int'(v[2:0]) + 6 * int'(v[5:3]) + 36 * int'(v[8:6]);
  endfunction

  typedef struct {
    logic       clr, ld, en, up;
    logic [7:0] lv;
    logic [7:0] eq;
    logic       etc, eerr, eco;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl[NV];

  initial begin
    int pulses;
    int model;
    logic [8:0] hold_q;

    //           clr ld en up  lv     q      tc err co(pre-edge)
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b1,8'h00,8'h00,1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b0,1'b1,1'b1,1'b1,8'h57,8'h57,1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b0,1'b1,1'b1,8'h00,8'h58,1'b0,1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b1,1'b0,1'b1,8'hA3,8'h93,1'b0,1'b1,1'b0};
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b1,8'h00,8'h93,1'b0,1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b0,1'b1,1'b0,8'h00,8'h92,1'b0,1'b0,1'b0};
    tbl[6]  = '{1'b0,1'b1,1'b0,1'b1,8'h99,8'h99,1'b1,1'b0,1'b0};
    tbl[7]  = '{1'b0,1'b0,1'b1,1'b1,8'h00,8'h00,1'b0,1'b0,1'b1};
    tbl[8]  = '{1'b0,1'b0,1'b1,1'b0,8'h00,8'h99,1'b0,1'b0,1'b1};
    tbl[9]  = '{1'b0,1'b1,1'b0,1'b0,8'hF0,8'h90,1'b0,1'b1,1'b0};
    tbl[10] = '{1'b1,1'b1,1'b1,1'b0,8'h55,8'h00,1'b1,1'b0,1'b0};
    tbl[11] = '{1'b0,1'b1,1'b0,1'b1,8'h3C,8'h39,1'b0,1'b1,1'b0};
    tbl[12] = '{1'b0,1'b0,1'b1,1'b1,8'h00,8'h40,1'b0,1'b0,1'b0};
    tbl[13] = '{1'b0,1'b0,1'b1,1'b0,8'h00,8'h39,1'b0,1'b0,1'b0};
    tbl[14] = '{1'b1,1'b0,1'b1,1'b1,8'h00,8'h00,1'b0,1'b0,1'b0};

    tick();

    for (int i = 0; i < NV; i++) begin
      a_clear = tbl[i].clr; a_load = tbl[i].ld; a_en = tbl[i].en;
      a_up = tbl[i].up; a_lv = tbl[i].lv;
      #1;
      chk($sformatf("vec%0d co", i), 32'(a_co), 32'(tbl[i].eco));
      tick();
      chk($sformatf("vec%0d q", i), 32'(a_q), 32'(tbl[i].eq));
      chk($sformatf("vec%0d tc", i), 32'(a_tc), 32'(tbl[i].etc));
      chk($sformatf("vec%0d load_err", i), 32'(a_err), 32'(tbl[i].eerr));
    end

    // clear from an arbitrary loaded value
    a_clear = 1'b0; a_en = 1'b0; a_load = 1'b1;
    a_lv = {4'($urandom_range(9)), 4'($urandom_range(9, 1))};
    tick();
    a_load = 1'b0; a_clear = 1'b1;
    tick();
    a_clear = 1'b0; a_up = 1'b1; #1;
    chk("clr q", 32'(a_q), 32'h0);
    chk("clr load_err", 32'(a_err), 32'h0);
    chk("clr tc up", 32'(a_tc), 32'h0);
    a_up = 1'b0; #1;
    chk("clr tc down", 32'(a_tc), 32'h1);

    // full up-count 0..99, single carry pulse at the wrap
    a_up = 1'b1; a_en = 1'b1; pulses = 0;
    for (int i = 0; i < 99; i++) begin
      if (a_co) pulses++;
      tick();
    end
    chk("up99 q", 32'(a_q), 32'h99);
    chk("up99 tc", 32'(a_tc), 32'h1);
    chk("up99 co", 32'(a_co), 32'h1);
    chk("up99 early co", 32'(pulses), 32'h0);
    tick();
    chk("wrap q", 32'(a_q), 32'h00);
    chk("wrap co", 32'(a_co), 32'h0);

    // down from 0 wraps to all nines; direction flip takes effect next edge
    a_clear = 1'b1; tick();
    a_clear = 1'b0; a_up = 1'b0; #1;
    chk("down0 co", 32'(a_co), 32'h1);
    tick();
    chk("down wrap q", 32'(a_q), 32'h99);
    tick();
    chk("down q98", 32'(a_q), 32'h98);
    a_up = 1'b1;
    tick();
    chk("flip q99", 32'(a_q), 32'h99);
    a_en = 1'b0;

    // mod-6, 3 digits: 216 enabled edges return to 0 with one co pulse
    b_clear = 1'b1; tick();
    b_clear = 1'b0; b_up = 1'b1; b_en = 1'b1; pulses = 0;
    for (int i = 0; i < 216; i++) begin
      if (b_co) pulses++;
      tick();
    end
    chk("m6 wrap q", 32'(b_q), 32'h0);
    chk("m6 co pulses", 32'(pulses), 32'h1);

    model = 0;
    for (int i = 0; i < 400; i++) begin
      b_en = 1'($urandom_range(1));
      if (b_en) model = (model + 1) % 216;
      tick();
      if (i % 100 == 99) chk($sformatf("m6 rand%0d", i), 32'(dec_b(b_q)), 32'(model));
    end
    b_en = 1'b0;
    tick();
    hold_q = b_q;
    chk("m6 hold start", 32'(dec_b(b_q)), 32'(model));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("m6 hold%0d", i), 32'(b_q), 32'(hold_q));
    end

    // clamp on the mod-6 digit width
    b_load = 1'b1; b_lv = {3'd7, 3'd6, 3'd2};
    tick();
    b_load = 1'b0;
    chk("m6 clamp q", 32'(b_q), 32'({3'd5, 3'd5, 3'd2}));
    chk("m6 clamp err", 32'(b_err), 32'h1);
    tick();
    chk("m6 err clears", 32'(b_err), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
